// File: rtl/sw_oport_arb.sv
// sw_oport_arb: per-output-port packet scheduler.
// Shares one output FIFO between NIN input FIFOs. Each input's head word is
// examined combinationally; whole packets are granted round-robin to inputs
// whose header addresses this port, and a packet is never interleaved.
//
// Header word: dst = [DSTW-1:0], len = [DSTW+LENW-1:DSTW] (body words that follow).
//
// Ports:
//   clk     clock
//   rst     asynchronous active-low reset
//   idata   head words of the input FIFOs, input i at [i*DW +: DW]
//   iempty  input FIFO empty flags
//   ire     input FIFO read enables (one-hot or zero)
//   ofull   output FIFO full flag
//   odata   word written to the output FIFO
//   owe     output FIFO write enable
//   busy    multi-word packet transfer in progress
//   grant   index of the current/last granted input
//   err     one-cycle watchdog abort pulse
//
// Optional feature: define SW_OPORT_ARB_WDOG_EN to abort a transfer whose
// granted input stays empty for WDOG consecutive cycles. Without it err is 0
// and a transfer waits indefinitely.

`ifndef PKTW
`define PKTW 8
`endif

module sw_oport_arb #(
  parameter int NIN  = 4,
  parameter int DW   = `PKTW + 1,
  parameter int DSTW = 2,
  parameter int LENW = 4,
  parameter int PORT = 0,
  parameter int WDOG = 16,
  localparam int GW  = $clog2(NIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN*DW-1:0] idata,
  input  logic [NIN-1:0]    iempty,
  output logic [NIN-1:0]    ire,
  input  logic              ofull,
  output logic [DW-1:0]     odata,
  output logic              owe,
  output logic              busy,
  output logic [GW-1:0]     grant,
  output logic              err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [DSTW-1:0] PORT_ID = DSTW'(PORT);

  logic [0:0]      state;
  logic [GW-1:0]   rr;
  logic [LENW-1:0] cnt;

  logic [NIN-1:0]  req;
  logic            win_vld;
  logic [GW-1:0]   win;
  logic            sel_vld;
  logic [GW-1:0]   sel;
  logic [LENW-1:0] sel_len;
  logic            xfer_go;

  function automatic logic [GW-1:0] nxt(input logic [GW-1:0] x);
    return (x == GW'(NIN - 1)) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      req[i] = !iempty[i] && (idata[i*DW +: DSTW] == PORT_ID);
    end
  end

  // Scan from rr upward with wrap; one extra bit keeps the sum exact for
  // non-power-of-two NIN before the modulo subtraction.
  always_comb begin
    logic [GW:0] s;
    win_vld = 1'b0;
    win     = '0;
    s       = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      s = {1'b0, rr} + (GW+1)'(k);
      if (s >= (GW+1)'(NIN)) s = s - (GW+1)'(NIN);
      if (!win_vld && req[s[GW-1:0]]) begin
        win_vld = 1'b1;
        win     = s[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_vld = (state == XFER) || win_vld;
    sel     = (state == XFER) ? grant : win;
    odata   = sel_vld ? idata[sel*DW +: DW] : '0;
    sel_len = idata[sel*DW + DSTW +: LENW];
    if (state == IDLE) xfer_go = win_vld && !ofull;
    else               xfer_go = !iempty[grant] && !ofull;
    owe = xfer_go;
    ire = xfer_go ? (NIN'(1'b1) << sel) : '0;
  end

`ifdef SW_OPORT_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG + 1);
  logic [WCW-1:0] wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= '0;
      cnt   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
      wd    <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          wd <= '0;
          if (xfer_go) begin
            grant <= win;
            if (sel_len == '0) begin
              rr <= nxt(win);
            end else begin
              cnt   <= sel_len;
              busy  <= 1'b1;
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (xfer_go) begin
            wd  <= '0;
            cnt <= cnt - 1'b1;
            if (cnt == LENW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              rr    <= nxt(grant);
            end
          end else if (iempty[grant]) begin
            // Only empty-input stalls count; output backpressure is never an abort.
            if (wd == WCW'(WDOG - 1)) begin
              wd    <= '0;
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
              rr    <= nxt(grant);
            end else begin
              wd <= wd + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= '0;
      cnt   <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer_go) begin
            grant <= win;
            if (sel_len == '0) begin
              rr <= nxt(win);
            end else begin
              cnt   <= sel_len;
              busy  <= 1'b1;
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (xfer_go) begin
            cnt <= cnt - 1'b1;
            if (cnt == LENW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              rr    <= nxt(grant);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sw_oport_arb.sv
// tb_sw_oport_arb: scoreboard bench for sw_oport_arb (NIN=4, DW=9, PORT=0).
// The bench models the input FIFOs as queues; expected output words are
// queued when packets are loaded, in the order arbitration must produce them.
module tb_sw_oport_arb;
  localparam int NIN = 4;
  localparam int DW  = 9;
  localparam int GW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NIN*DW-1:0] idata = '0;
  logic [NIN-1:0]    iempty = '1;
  logic [NIN-1:0]    ire;
  logic              ofull = 1'b0;
  logic [DW-1:0]     odata;
  logic              owe;
  logic              busy;
  logic [GW-1:0]     grant;
  logic              err;

  sw_oport_arb #(.NIN(NIN), .DW(DW), .DSTW(2), .LENW(4), .PORT(0), .WDOG(16)) dut (
    .clk(clk), .rst(rst), .idata(idata), .iempty(iempty), .ire(ire),
    .ofull(ofull), .odata(odata), .owe(owe), .busy(busy), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]  fq [NIN][$];
  logic [DW-1:0]  exp_q [$];
  int unsigned    n_vec = 0;
  int unsigned    n_err = 0;
  int unsigned    owe_cnt;
  logic [NIN-1:0] ire_s, ire_or;
  logic           owe_s, busy_s;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic update_fifo();
    for (int i = 0; i < NIN; i++) begin
      iempty[i] = (fq[i].size() == 0);
      idata[i*DW +: DW] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endtask

  task automatic push_pkt(input int unsigned in, input int unsigned dst,
                          input int unsigned len, input bit expect_out);
    logic [DW-1:0] w;
    w = {3'(in), 4'(len), 2'(dst)};
    fq[in].push_back(w);
    if (expect_out) exp_q.push_back(w);
    for (int unsigned j = 0; j < len; j++) begin
      w = {1'b1, 3'(in), 5'(j)};
      fq[in].push_back(w);
      if (expect_out) exp_q.push_back(w);
    end
    update_fifo();
  endtask

  // One clock: sample and check at negedge, pop read FIFOs just after posedge.
  task automatic step();
    logic [NIN-1:0] pop_m;
    @(negedge clk);
    ire_s  = ire;
    owe_s  = owe;
    busy_s = busy;
    ire_or = ire_or | ire;
    chk("owe_eq_or_ire", 32'(owe), 32'(|ire));
    chk("ire_onehot0", 32'($onehot0(ire)), 32'd1);
    chk("ire_while_empty", 32'(ire & iempty), 32'd0);
    chk("owe_while_full", 32'(owe & ofull), 32'd0);
    if (owe) begin
      owe_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_owe", 32'(owe), 32'd0);
      else chk("sb_odata", 32'(odata), 32'(exp_q.pop_front()));
    end
    pop_m = ire;
    @(posedge clk);
    #1;
    for (int i = 0; i < NIN; i++)
      if (pop_m[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    update_fifo();
  endtask

  task automatic do_reset(input bit check_now);
    rst = 1'b0;
    ofull = 1'b0;
    for (int i = 0; i < NIN; i++) fq[i].delete();
    exp_q.delete();
    update_fifo();
    #1;
    if (check_now) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ire", 32'(ire), 32'd0);
      chk("rst_owe", 32'(owe), 32'd0);
      chk("rst_odata", 32'(odata), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    owe_cnt = 0;
    ire_or  = '0;
  endtask

  initial begin
    // Single len=0 header on input 2: granted and written in the same cycle.
    do_reset(1'b1);
    push_pkt(2, 0, 0, 1'b1);
    step();
    chk("t1_ire", 32'(ire_s), 32'b0100);
    chk("t1_owe", 32'(owe_s), 32'd1);
    chk("t1_busy_during", 32'(busy_s), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_grant", 32'(grant), 32'd2);
    chk("t1_drain", exp_q.size(), 32'd0);

    // Three len=2 packets: in0, in1, in3 back to back, 9 owe cycles.
    do_reset(1'b0);
    push_pkt(0, 0, 2, 1'b1);
    push_pkt(1, 0, 2, 1'b1);
    push_pkt(3, 0, 2, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t2_owe_each", 32'(owe_s), 32'd1);
    end
    chk("t2_owe_cnt", owe_cnt, 32'd9);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_grant", 32'(grant), 32'd3);
    chk("t2_drain", exp_q.size(), 32'd0);

    // Input 1 addressed elsewhere, input 2 valid.
    do_reset(1'b0);
    push_pkt(1, 1, 0, 1'b0);
    push_pkt(2, 0, 1, 1'b1);
    repeat (4) step();
    chk("t3_in1_never_read", 32'(ire_or[1]), 32'd0);
    chk("t3_in1_left", fq[1].size(), 32'd1);
    chk("t3_grant", 32'(grant), 32'd2);
    chk("t3_drain", exp_q.size(), 32'd0);

    // len=3 with ofull for 2 cycles mid-body.
    do_reset(1'b0);
    push_pkt(0, 0, 3, 1'b1);
    step();
    step();
    ofull = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t4_stall_owe", 32'(owe_s), 32'd0);
      chk("t4_stall_ire", 32'(ire_s), 32'd0);
      chk("t4_stall_busy", 32'(busy_s), 32'd1);
    end
    ofull = 1'b0;
    step();
    step();
    chk("t4_owe_cnt", owe_cnt, 32'd4);
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_in0_empty", fq[0].size(), 32'd0);
    chk("t4_drain", exp_q.size(), 32'd0);

    // Async reset mid-XFER (cnt=2) with rr nonzero beforehand.
    do_reset(1'b0);
    push_pkt(2, 0, 0, 1'b1);
    step();
    push_pkt(1, 0, 3, 1'b1);
    step();
    step();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NIN; i++) fq[i].delete();
    exp_q.delete();
    update_fifo();
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_owe", 32'(owe), 32'd0);
    chk("t5_rst_ire", 32'(ire), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    owe_cnt = 0;
    repeat (2) step();
    chk("t5_quiet", owe_cnt, 32'd0);
    push_pkt(1, 0, 0, 1'b1);
    push_pkt(3, 0, 0, 1'b1);
    step();
    chk("t5_rr_zero_first", 32'(ire_s), 32'b0010);
    step();
    chk("t5_grant", 32'(grant), 32'd3);
    chk("t5_drain", exp_q.size(), 32'd0);

    // Maximum length body (len=15) after a len=0 packet.
    do_reset(1'b0);
    push_pkt(0, 0, 0, 1'b1);
    push_pkt(2, 0, 15, 1'b1);
    repeat (17) step();
    chk("t6_owe_cnt", owe_cnt, 32'd17);
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_drain", exp_q.size(), 32'd0);

`ifdef SW_OPORT_ARB_WDOG_EN
    // Watchdog: header len=2 on in0 with no body, in1 pending.
    do_reset(1'b0);
    push_pkt(1, 0, 0, 1'b0);
    fq[0].push_back({3'd0, 4'd2, 2'd0});
    exp_q.push_back({3'd0, 4'd2, 2'd0});
    exp_q.push_back({3'd1, 4'd0, 2'd0});
    update_fifo();
    step();
    for (int k = 0; k < 15; k++) begin
      step();
      chk("t7_no_err_yet", 32'(err), 32'd0);
    end
    step();
    chk("t7_err_pulse", 32'(err), 32'd1);
    chk("t7_busy_abort", 32'(busy), 32'd0);
    step();
    chk("t7_in1_granted", 32'(ire_s), 32'b0010);
    chk("t7_err_cleared", 32'(err), 32'd0);
    chk("t7_drain", exp_q.size(), 32'd0);
`else
    chk("t7_err_tied", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
